// File: rtl/recirc_sched_pkg.sv
// recirc_sched_pkg: shared types and helpers
// for the recirculation-mux scheduler.
package recirc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int unsigned MAX_REQ = 32;

  function automatic int unsigned cnt_width(
    input int unsigned hold
  );
    return $clog2(hold + 1);
  endfunction

  localparam int unsigned DEF_HOLD  = 8;
  localparam int unsigned DEF_CNT_W =
    cnt_width(DEF_HOLD);

  // First set bit at or above ptr, wrapping
  // inside the low n bits; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] g;
    int unsigned        idx;
    g = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && g == '0 && req[idx[4:0]])
        g[idx[4:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/recirc_mux_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick
// from the request vector and the pointer.
module rr_arbiter
  import recirc_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [MAX_REQ-1:0] req_w;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  always_comb begin
    req_w        = '0;
    req_w[N-1:0] = req;
    pick         = rr_pick(req_w, 32'(ptr), N);
    grant        = pick[N-1:0];
    valid        = |req;
  end

  assign unused_pick = ^pick;

endmodule

// File: rtl/recirc_mux_scheduler.sv
// recirc_mux_scheduler: shares one recirc-mux
// CDC channel between local requesters.
module recirc_mux_scheduler
  import recirc_sched_pkg::*;
#(
  parameter int unsigned g_requesters  = 4,
  parameter int unsigned g_width       = 8,
  parameter int unsigned g_hold_cycles = 8
) (
  input  logic                   i_clk_A,
  input  logic                   i_rst_A,
  input  logic                   i_en,
  input  logic [g_requesters-1:0] i_req,
  input  logic [g_requesters*g_width-1:0] i_data,
  output logic [g_requesters-1:0] o_ack,
  output logic [g_requesters-1:0] o_grant,
  output logic                   o_busy,
  output logic                   o_pulse_A,
  output logic [g_width-1:0]     o_data_A
);

  localparam int unsigned PW =
    (g_requesters > 1) ? $clog2(g_requesters) : 1;
  localparam int unsigned CW =
    cnt_width(g_hold_cycles);
  localparam logic [CW-1:0] HOLD_LD =
    CW'(g_hold_cycles - 1);
  localparam logic [PW-1:0] LAST =
    PW'(g_requesters - 1);

  if (g_hold_cycles < 1) begin : g_chk_hold
    $error("g_hold_cycles must be >= 1");
  end
  if (g_requesters < 2 ||
      g_requesters > MAX_REQ) begin : g_chk_req
    $error("g_requesters out of range");
  end

  state_t                  state;
  state_t                  nxt;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           nxt_cnt;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           win;
  logic [PW-1:0]           pick_idx;
  logic [g_requesters-1:0] pick;
  logic                    pick_vld;
  logic [g_width-1:0]      pick_data;
  logic [g_requesters-1:0] grant_q;
  logic [g_width-1:0]      data_q;
  logic                    start;
  logic                    done;

  rr_arbiter #(
    .N  (g_requesters),
    .PW (PW)
  ) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < g_requesters; i++) begin
      if (pick[i]) begin
        pick_idx  = PW'(i);
        pick_data = i_data[i*g_width +: g_width];
      end
    end
  end

  assign start = (state == IDLE) && i_en && pick_vld;
  assign done  = (state == HOLD) && (cnt == '0);

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    unique case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = PULSE;
      PULSE: begin
        nxt     = HOLD;
        nxt_cnt = HOLD_LD;
      end
      HOLD: begin
        if (cnt == '0) nxt = IDLE;
        else           nxt_cnt = cnt - 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_A or posedge i_rst_A) begin
    if (i_rst_A) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      win     <= '0;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      if (start) begin
        win     <= pick_idx;
        grant_q <= pick;
        data_q  <= pick_data;
      end
      if (done) begin
        grant_q <= '0;
        ptr     <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

  assign o_ack     = (state == LOAD) ? grant_q : '0;
  assign o_grant   = grant_q;
  assign o_busy    = (state != IDLE);
  assign o_pulse_A = (state == PULSE);
  assign o_data_A  = data_q;

endmodule

// File: tb/tb_recirc_mux_scheduler.sv
// tb_recirc_mux_scheduler: directed checks
// for the recirc-mux scheduler.
module tb_recirc_mux_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        pulse;
  logic [7:0]  dout;

  int pass_cnt;
  int total_cnt;

  recirc_mux_scheduler #(
    .g_requesters  (4),
    .g_width       (8),
    .g_hold_cycles (4)
  ) dut (
    .i_clk_A   (clk),
    .i_rst_A   (rst),
    .i_en      (en),
    .i_req     (req),
    .i_data    (data),
    .o_ack     (ack),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_pulse_A (pulse),
    .o_data_A  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    en   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 20) begin
      tick();
      n++;
      if (ack !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 20) begin
      tick();
      n++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [19:0] outs;
    req  = '0;
    data = '0;
    en   = 1'b0;
    rst  = 1'b1;
    #2;
    outs = {ack, grant, busy, pulse, dout, 2'b00};
    total_cnt++;
    if (outs !== 20'h0)
      $display("FAIL reset_outs got %h want 0", outs);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL reset_idle got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_single;
    int n;
    bit ok;
    bit flag;
    do_reset();
    req         = 4'b0010;
    data[15:8]  = 8'hA5;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok) $display("FAIL single_timeout got none want ack");
    else pass_cnt++;
    total_cnt++;
    if (ack !== 4'b0010)
      $display("FAIL single_ack got %b want 0010", ack);
    else pass_cnt++;
    total_cnt++;
    if (dout !== 8'hA5)
      $display("FAIL single_data got %h want a5", dout);
    else pass_cnt++;
    total_cnt++;
    if (pulse !== 1'b0)
      $display("FAIL single_early_pulse got %b want 0", pulse);
    else pass_cnt++;
    req  = '0;
    data = '0;
    tick();
    total_cnt++;
    if (pulse !== 1'b1 || ack !== 4'b0000)
      $display("FAIL single_pulse got %b/%b want 1/0000",
               pulse, ack);
    else pass_cnt++;
    flag = 1'b1;
    repeat (4) begin
      tick();
      if (pulse !== 1'b0 || busy !== 1'b1) flag = 1'b0;
    end
    total_cnt++;
    if (!flag)
      $display("FAIL single_hold got %b/%b want 0/1",
               pulse, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || grant !== 4'b0000)
      $display("FAIL single_end got %b/%b want 0/0000",
               busy, grant);
    else pass_cnt++;
    total_cnt++;
    if (dout !== 8'hA5)
      $display("FAIL single_retain got %h want a5", dout);
    else pass_cnt++;
  endtask

  task automatic test_round_robin;
    int n;
    bit ok;
    logic [3:0] exp_ack;
    logic [7:0] exp_dat;
    do_reset();
    data = 32'h13121110;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % 4);
      exp_dat = 8'h10 + 8'(k % 4);
      wait_ack(n, ok);
      total_cnt++;
      if (!ok || ack !== exp_ack)
        $display("FAIL rr_ack%0d got %b want %b",
                 k, ack, exp_ack);
      else pass_cnt++;
      total_cnt++;
      if (dout !== exp_dat)
        $display("FAIL rr_data%0d got %h want %h",
                 k, dout, exp_dat);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (n != 7)
          $display("FAIL rr_gap%0d got %0d want 7", k, n);
        else pass_cnt++;
      end
    end
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_priority;
    int n;
    bit ok;
    do_reset();
    req = 4'b0001;
    data = 32'h00220020;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok || ack !== 4'b0001)
      $display("FAIL prio_first got %b want 0001", ack);
    else pass_cnt++;
    req = '0;
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL prio_idle got busy want idle");
    else pass_cnt++;
    req = 4'b0101;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok || ack !== 4'b0100 || dout !== 8'h22)
      $display("FAIL prio_req2 got %b/%h want 0100/22",
               ack, dout);
    else pass_cnt++;
    req = 4'b0001;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok || ack !== 4'b0001 || dout !== 8'h20)
      $display("FAIL prio_req0 got %b/%h want 0001/20",
               ack, dout);
    else pass_cnt++;
    req = '0;
    wait_idle(ok);
  endtask

  task automatic test_enable;
    int n;
    bit ok;
    bit flag;
    do_reset();
    en          = 1'b0;
    req         = 4'b1000;
    data[31:24] = 8'h3C;
    flag = 1'b1;
    repeat (10) begin
      tick();
      if (ack !== 4'b0000 || busy !== 1'b0) flag = 1'b0;
    end
    total_cnt++;
    if (!flag)
      $display("FAIL en_block got %b/%b want 0000/0",
               ack, busy);
    else pass_cnt++;
    en = 1'b1;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok || ack !== 4'b1000 || dout !== 8'h3C)
      $display("FAIL en_start got %b/%h want 1000/3c",
               ack, dout);
    else pass_cnt++;
    tick();
    tick();
    en          = 1'b0;
    data[31:24] = 8'hFF;
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL en_complete got busy want idle");
    else pass_cnt++;
    total_cnt++;
    if (dout !== 8'h3C)
      $display("FAIL en_data got %h want 3c", dout);
    else pass_cnt++;
    flag = 1'b1;
    repeat (3) begin
      tick();
      if (ack !== 4'b0000 || busy !== 1'b0) flag = 1'b0;
    end
    total_cnt++;
    if (!flag)
      $display("FAIL en_regrant got %b/%b want 0000/0",
               ack, busy);
    else pass_cnt++;
    req = '0;
    en  = 1'b1;
  endtask

  task automatic test_reset_hold;
    int n;
    bit ok;
    do_reset();
    req        = 4'b0010;
    data[15:8] = 8'h77;
    wait_ack(n, ok);
    total_cnt++;
    if (!ok || ack !== 4'b0010)
      $display("FAIL rh_ack got %b want 0010", ack);
    else pass_cnt++;
    req       = 4'b0001;
    data[7:0] = 8'h55;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (grant !== 4'b0000)
      $display("FAIL rh_grant got %b want 0000", grant);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || pulse !== 1'b0 || ack !== 4'b0000)
      $display("FAIL rh_busy got %b/%b/%b want 0/0/0000",
               busy, pulse, ack);
    else pass_cnt++;
    total_cnt++;
    if (dout !== 8'h00)
      $display("FAIL rh_data got %h want 00", dout);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (ack !== 4'b0001 || dout !== 8'h55)
      $display("FAIL rh_regrant got %b/%h want 0001/55",
               ack, dout);
    else pass_cnt++;
    req = '0;
    wait_idle(ok);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst  = 1'b1;
    en   = 1'b0;
    req  = '0;
    data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_enable();
    test_reset_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
